// File: rtl/msrv32_alu_issue.sv
// Issue stage feeding the ALU: decodes OP/OP-IMM/LUI/AUIPC into operands and opcode.
// Optional 1-entry skid buffer when MSRV32_ISSUE_SKID_EN is defined.
module msrv32_alu_issue #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int CHECK_FUNCT7 = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [31:0]           instr_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     rs1_in,
  input  logic [DATA_W-1:0]     rs2_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_W-1:0]     op_1_out,
  output logic [DATA_W-1:0]     op_2_out,
  output logic [3:0]            alu_opcode_out,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic                  wr_en_out,
  output logic                  illegal_out
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [DATA_W-1:0]     op_1;
    logic [DATA_W-1:0]     op_2;
    logic [3:0]            alu_opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr_en;
    logic                  illegal;
  } entry_t;

  entry_t     dec;
  entry_t     out_q;
  logic       out_valid;
  logic       up_xfer;
  logic       illegal;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_std;

  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];
  assign f7_std = (funct7 == F7_ZERO) || (funct7 == F7_ALT);

  // Illegal encodings still issue, but with zeroed operands/opcode and no writeback.
  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    dec.rd  = instr_in[11:7];
    unique case (instr_in[6:0])
      OPC_OP: begin
        dec.op_1       = rs1_in;
        dec.op_2       = rs2_in;
        dec.alu_opcode = {instr_in[30] && (funct3 == 3'b000 || funct3 == 3'b101), funct3};
        if (CHECK_FUNCT7 != 0 && !f7_std) illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.op_1 = rs1_in;
        if (funct3 == 3'b001 || funct3 == 3'b101)
          dec.op_2 = {27'b0, instr_in[24:20]};
        else
          dec.op_2 = {{20{instr_in[31]}}, instr_in[31:20]};
        dec.alu_opcode = {instr_in[30] && (funct3 == 3'b101), funct3};
        if (CHECK_FUNCT7 != 0) begin
          if (funct3 == 3'b001 && funct7 != F7_ZERO) illegal = 1'b1;
          if (funct3 == 3'b101 && !f7_std) illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.op_2 = {instr_in[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec.op_1 = pc_in;
        dec.op_2 = {instr_in[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec.op_1       = '0;
      dec.op_2       = '0;
      dec.alu_opcode = '0;
    end
    dec.illegal = illegal;
    dec.wr_en   = !illegal && (dec.rd != '0);
  end

  assign up_xfer = valid_in && ready_out;

`ifdef MSRV32_ISSUE_SKID_EN
  entry_t skid_q;
  logic   skid_valid;

  assign ready_out = !skid_valid;

  // The skid entry always drains ahead of new input so issue order is preserved.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (flush_in) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || ready_in) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= up_xfer;
        if (up_xfer) out_q <= dec;
      end
    end else if (up_xfer) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end
`else
  assign ready_out = !out_valid || ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush_in) begin
      out_valid <= 1'b0;
    end else if (ready_out) begin
      out_valid <= valid_in;
      if (valid_in) out_q <= dec;
    end
  end
`endif

  assign valid_out      = out_valid;
  assign op_1_out       = out_q.op_1;
  assign op_2_out       = out_q.op_2;
  assign alu_opcode_out = out_q.alu_opcode;
  assign rd_addr_out    = out_q.rd;
  assign wr_en_out      = out_q.wr_en;
  assign illegal_out    = out_q.illegal;

endmodule

// File: tb/tb_msrv32_alu_issue.sv
// Self-checking bench for msrv32_alu_issue: directed scenarios plus randomized traffic
// scored against a queue-based reference model. Honours MSRV32_ISSUE_SKID_EN.
module tb_msrv32_alu_issue;

`ifdef MSRV32_ISSUE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] op_1;
  logic [31:0] op_2;
  logic [3:0]  alu_opcode;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  msrv32_alu_issue dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .flush_in       (flush_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .instr_in       (instr_in),
    .pc_in          (pc_in),
    .rs1_in         (rs1_in),
    .rs2_in         (rs2_in),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .op_1_out       (op_1),
    .op_2_out       (op_2),
    .alu_opcode_out (alu_opcode),
    .rd_addr_out    (rd_addr),
    .wr_en_out      (wr_en),
    .illegal_out    (illegal)
  );

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  opc;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
    logic        dc;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  opc;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
    logic        dc;
  } vec_t;

  vec_t vecs[$];

  // Reference: what execute should receive for one instruction (dc = operands unspecified).
  function automatic exp_t ref_model(input logic [31:0] instr, input logic [31:0] pc,
                                     input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    int   f3;
    int   f7;
    int   simm;
    logic alt;
    f3     = int'(instr[14:12]);
    f7     = int'(instr[31:25]);
    simm   = $signed(instr[31:20]);
    e.op1  = 32'd0;
    e.op2  = 32'd0;
    e.opc  = 4'd0;
    e.rd   = instr[11:7];
    e.ill  = 1'b0;
    e.dc   = 1'b0;
    alt    = 1'b0;
    case (instr[6:0])
      7'h33: begin
        e.op1 = rs1;
        e.op2 = rs2;
        if (f3 == 0 || f3 == 5) alt = instr[30];
        e.opc = {alt, instr[14:12]};
        if (f7 != 0 && f7 != 32) begin e.ill = 1'b1; e.dc = 1'b1; end
      end
      7'h13: begin
        e.op1 = rs1;
        if (f3 == 1 || f3 == 5) e.op2 = 32'(instr[24:20]);
        else                    e.op2 = simm;
        if (f3 == 5) alt = instr[30];
        e.opc = {alt, instr[14:12]};
        if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32)) begin
          e.ill = 1'b1;
          e.dc  = 1'b1;
        end
      end
      7'h37: e.op2 = instr & 32'hFFFF_F000;
      7'h17: begin
        e.op1 = pc;
        e.op2 = instr & 32'hFFFF_F000;
      end
      default: e.ill = 1'b1;
    endcase
    e.wr = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    int          f;
    r = $urandom;
    k = $urandom_range(0, 9);
    f = $urandom_range(0, 3);
    case (k)
      0, 1, 2: r[6:0] = 7'h33;
      3, 4, 5: r[6:0] = 7'h13;
      6:       r[6:0] = 7'h37;
      7:       r[6:0] = 7'h17;
      8:       r[6:0] = 7'($urandom);
      default: begin r[6:0] = 7'h33; r[11:7] = 5'd0; end
    endcase
    if (f == 0) r[31:25] = 7'h00;
    else if (f == 1) r[31:25] = 7'h20;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic rdy, input logic fl);
    valid_in = v;
    instr_in = ins;
    rs1_in   = r1;
    rs2_in   = 32'h11;
    pc_in    = 32'h0;
    ready_in = rdy;
    flush_in = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({valid_out, wr_en, illegal, op_1, op_2, alu_opcode, rd_addr} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got %h/%h/%h v=%b want all zero", op_1, op_2, alu_opcode, valid_out);
    end
    n_cmp++;
    if (ready_out !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_ready: got %b want 1", ready_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    vecs.delete();
    vecs.push_back(vec_t'{32'h002081B3, 32'h0,   32'h5,        32'h7,  32'h5,        32'h7,        4'h0, 5'd3,  1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h402081B3, 32'h0,   32'h5,        32'h7,  32'h5,        32'h7,        4'h8, 5'd3,  1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h40335293, 32'h0,   32'h80000000, 32'h0,  32'h80000000, 32'h3,        4'hD, 5'd5,  1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'hFFF00093, 32'h0,   32'h0,        32'h55, 32'h0,        32'hFFFFFFFF, 4'h0, 5'd1,  1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h40000093, 32'h0,   32'h0,        32'h0,  32'h0,        32'h400,      4'h0, 5'd1,  1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h12345137, 32'h0,   32'hAA,       32'hBB, 32'h0,        32'h12345000, 4'h0, 5'd2,  1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h00001217, 32'h100, 32'h1,        32'h2,  32'h100,      32'h1000,     4'h0, 5'd4,  1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h4020A1B3, 32'h0,   32'h9,        32'h8,  32'h9,        32'h8,        4'h2, 5'd3,  1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h00209093, 32'h0,   32'hF,        32'h0,  32'hF,        32'h2,        4'h1, 5'd1,  1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h01F35293, 32'h0,   32'h7,        32'h0,  32'h7,        32'h1F,       4'h5, 5'd5,  1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h00000033, 32'h0,   32'h1,        32'h2,  32'h1,        32'h2,        4'h0, 5'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h00000FFF, 32'h0,   32'h3,        32'h4,  32'h0,        32'h0,        4'h0, 5'd31, 1'b0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{32'h022081B3, 32'h0,   32'h5,        32'h7,  32'h0,        32'h0,        4'h0, 5'd3,  1'b0, 1'b1, 1'b1});
    vecs.push_back(vec_t'{32'h40209093, 32'h0,   32'h5,        32'h7,  32'h0,        32'h0,        4'h0, 5'd1,  1'b0, 1'b1, 1'b1});
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].instr, vecs[i].rs1, 1'b1, 1'b0);
      rs2_in = vecs[i].rs2;
      pc_in  = vecs[i].pc;
      @(negedge clk);
      valid_in = 1'b0;
      #1;
      n_cmp++;
      if (valid_out !== 1'b1) begin n_bad++; $display("[TB] FAIL decode[%0d].valid: got %b want 1", i, valid_out); end
      if (!vecs[i].dc) begin
        n_cmp++;
        if (op_1 !== vecs[i].op1) begin n_bad++; $display("[TB] FAIL decode[%0d].op1: got %h want %h", i, op_1, vecs[i].op1); end
        n_cmp++;
        if (op_2 !== vecs[i].op2) begin n_bad++; $display("[TB] FAIL decode[%0d].op2: got %h want %h", i, op_2, vecs[i].op2); end
        n_cmp++;
        if (alu_opcode !== vecs[i].opc) begin n_bad++; $display("[TB] FAIL decode[%0d].opcode: got %h want %h", i, alu_opcode, vecs[i].opc); end
      end
      n_cmp++;
      if (rd_addr !== vecs[i].rd) begin n_bad++; $display("[TB] FAIL decode[%0d].rd: got %0d want %0d", i, rd_addr, vecs[i].rd); end
      n_cmp++;
      if (wr_en !== vecs[i].wr) begin n_bad++; $display("[TB] FAIL decode[%0d].wr_en: got %b want %b", i, wr_en, vecs[i].wr); end
      n_cmp++;
      if (illegal !== vecs[i].ill) begin n_bad++; $display("[TB] FAIL decode[%0d].illegal: got %b want %b", i, illegal, vecs[i].ill); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h002081B3, 32'h100 + 32'(i), 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (ready_out !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_ready[%0d]: got %b want 1", i, ready_out); end
      if (i > 0) begin
        n_cmp++;
        if (valid_out !== 1'b1 || op_1 !== 32'h100 + 32'(i - 1)) begin
          n_bad++;
          $display("[TB] FAIL b2b_issue[%0d]: got v=%b op1=%h want v=1 op1=%h", i, valid_out, op_1, 32'h100 + 32'(i - 1));
        end
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (valid_out !== 1'b1 || op_1 !== 32'h103) begin n_bad++; $display("[TB] FAIL b2b_last: got v=%b op1=%h want v=1 op1=103", valid_out, op_1); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h2, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (valid_out !== 1'b1 || op_1 !== 32'h1) begin n_bad++; $display("[TB] FAIL bp_first: got v=%b op1=%h want v=1 op1=1", valid_out, op_1); end
    n_cmp++;
    if (ready_out !== SKID) begin n_bad++; $display("[TB] FAIL bp_ready_c1: got %b want %b", ready_out, SKID); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b1, 32'h002081B3, SKID ? 32'h3 : 32'h2, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (ready_out !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_ready_stall[%0d]: got %b want 0", c, ready_out); end
      n_cmp++;
      if (valid_out !== 1'b1 || op_1 !== 32'h1 || rd_addr !== 5'd3) begin
        n_bad++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b op1=%h rd=%0d want v=1 op1=1 rd=3", c, valid_out, op_1, rd_addr);
      end
    end
    @(negedge clk);
    drive(!SKID, 32'h002081B3, 32'h2, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (ready_out !== !SKID) begin n_bad++; $display("[TB] FAIL bp_ready_release: got %b want %b", ready_out, !SKID); end
    n_cmp++;
    if (op_1 !== 32'h1) begin n_bad++; $display("[TB] FAIL bp_hold_release: got op1=%h want 1", op_1); end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (valid_out !== 1'b1 || op_1 !== 32'h2) begin n_bad++; $display("[TB] FAIL bp_second: got v=%b op1=%h want v=1 op1=2", valid_out, op_1); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_drained: got v=%b op1=%h want v=0", valid_out, op_1); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h10, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h20, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h30, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (valid_out !== 1'b1 || ready_out !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_pre: got v=%b rdy=%b want v=1 rdy=0", valid_out, ready_out); end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_post: got v=%b rdy=%b want v=0 rdy=1", valid_out, ready_out); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_nothing_left[%0d]: got v=%b op1=%h want v=0", c, valid_out, op_1); end
    end
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h40, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_drops_input: got v=%b op1=%h want v=0", valid_out, op_1); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, 32'h402081B3, 32'h77, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h88, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid_out, wr_en, illegal, op_1, op_2, alu_opcode, rd_addr} !== '0) begin
      n_bad++;
      $display("[TB] FAIL async_reset_outputs: got v=%b op1=%h op2=%h opc=%h want all zero", valid_out, op_1, op_2, alu_opcode);
    end
    n_cmp++;
    if (ready_out !== 1'b1) begin n_bad++; $display("[TB] FAIL async_reset_ready: got %b want 1", ready_out); end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL async_reset_skid_cleared: got v=%b op1=%h want v=0", valid_out, op_1); end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    logic        stall_prev;
    logic [78:0] snap;
    logic        exp_rdy;
    stall_prev = 1'b0;
    snap       = '0;
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      valid_in = ($urandom_range(0, 9) < 7);
      ready_in = ($urandom_range(0, 9) < 6);
      flush_in = ($urandom_range(0, 49) == 0);
      instr_in = rand_instr();
      pc_in    = $urandom;
      rs1_in   = $urandom;
      rs2_in   = $urandom;
      #1;
      n_cmp++;
      if (valid_out !== (q.size() != 0)) begin
        n_bad++;
        $display("[TB] FAIL rnd_valid@%0d: got %b want %b", c, valid_out, q.size() != 0);
      end
      exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || ready_in);
      n_cmp++;
      if (ready_out !== exp_rdy) begin
        n_bad++;
        $display("[TB] FAIL rnd_ready@%0d: got %b want %b", c, ready_out, exp_rdy);
      end
      if (stall_prev) begin
        n_cmp++;
        if ({op_1, op_2, alu_opcode, rd_addr, wr_en, illegal, valid_out} !== snap) begin
          n_bad++;
          $display("[TB] FAIL rnd_stable@%0d: got %h want %h", c, {op_1, op_2, alu_opcode, rd_addr, wr_en, illegal, valid_out}, snap);
        end
      end
      if (valid_out === 1'b1 && ready_in) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL rnd_spurious@%0d: got issue op1=%h want nothing", c, op_1);
        end else begin
          e = q.pop_front();
          if (!e.dc && {op_1, op_2, alu_opcode} !== {e.op1, e.op2, e.opc}) begin
            n_bad++;
            $display("[TB] FAIL rnd_operands@%0d: got %h/%h/%h want %h/%h/%h", c, op_1, op_2, alu_opcode, e.op1, e.op2, e.opc);
          end else if ({rd_addr, wr_en, illegal} !== {e.rd, e.wr, e.ill}) begin
            n_bad++;
            $display("[TB] FAIL rnd_ctrl@%0d: got rd=%0d wr=%b ill=%b want rd=%0d wr=%b ill=%b", c, rd_addr, wr_en, illegal, e.rd, e.wr, e.ill);
          end
        end
      end
      stall_prev = (valid_out === 1'b1) && !ready_in && !flush_in;
      snap       = {op_1, op_2, alu_opcode, rd_addr, wr_en, illegal, valid_out};
      if (flush_in) q.delete();
      else if (valid_in && ready_out === 1'b1) q.push_back(ref_model(instr_in, pc_in, rs1_in, rs2_in));
      @(negedge clk);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/msrv32_alu_issue.md
Name: msrv32_alu_issue

Overview:
- Producer end of the ALU interface: the issue stage that drives the ALU's operand and opcode inputs for execute.
- Accepts a decoded instruction word plus register-file read data from decode using a valid/ready handshake.
- Builds op_1, op_2 and the 4-bit ALU opcode {alt bit, funct3}.
- Holds them in a pipeline register toward execute, with backpressure and flush.

Parameters:
- DATA_W, 32, operand width; only 32 supported.
- REG_ADDR_W, 5, register index width.
- CHECK_FUNCT7, 1, when 1 flags reserved funct7 encodings of OP as illegal.

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- flush_in  input  1  synchronous flush of all held entries
- valid_in  input  1  upstream instruction valid
- ready_out  output  1  stage can accept
- instr_in  input  32  instruction word
- pc_in  input  32  instruction PC
- rs1_in  input  32  rs1 read data
- rs2_in  input  32  rs2 read data
- valid_out  output  1  issued entry valid
- ready_in  input  1  execute accepts
- op_1_out  output  32  ALU operand 1
- op_2_out  output  32  ALU operand 2
- alu_opcode_out  output  4  {alt, funct3}
- rd_addr_out  output  5  destination register
- wr_en_out  output  1  result writes rd (0 when rd==0 or illegal)
- illegal_out  output  1  unsupported encoding

Behaviour:
- Reset (async, rst_n_in=0): valid_out, wr_en_out, illegal_out=0; op_1_out, op_2_out, alu_opcode_out, rd_addr_out=0; ready_out=1; skid entry empty.
- Handshake:
  - Upstream transfer when valid_in && ready_out; downstream transfer when valid_out && ready_in.
  - Outputs are registered: an accepted instruction appears on valid_out the next cycle (latency 1).
  - While valid_out && !ready_in, all outputs hold stable.
- Decode by instr_in[6:0]:
  - OP (0110011): op1=rs1, op2=rs2, opcode={instr[30], funct3}. instr[30] is honoured only for funct3 000/101, else forced 0.
  - OP-IMM (0010011): op1=rs1, op2=sign-extended instr[31:20].
    - funct3 001/101: op2={27'b0, instr[24:20]}.
    - alt=instr[30] only for funct3 101; ADDI alt is always 0.
  - LUI (0110111): op1=0, op2={instr[31:12], 12'b0}, opcode 0000.
  - AUIPC (0010111): op1=pc_in, op2={instr[31:12], 12'b0}, opcode 0000.
  - Any other opcode: illegal_out=1, wr_en_out=0, opcode 0000, operands 0. The instruction is still issued, so execute can raise an exception.
  - CHECK_FUNCT7=1: OP with funct7 not in {0000000, 0100000} → illegal. SLLI/SRLI/SRAI with instr[31:25] not in {0000000, 0100000}, or 0100000 on SLLI → illegal.
- rd_addr_out=instr[11:7]; wr_en_out = legal && rd!=0.
- Flush:
  - flush_in=1 clears valid_out and the skid entry on the next edge.
  - An upstream transfer in the same cycle is discarded.
  - ready_out=1 the following cycle.
- Simultaneous downstream transfer and upstream transfer: the output register loads the new entry with no bubble (full throughput).
- Mid-operation reset clears all state immediately regardless of handshake.

Optional Feature:
- Macro MSRV32_ISSUE_SKID_EN.
- Defined:
  - Adds a 1-entry skid buffer; ready_out is a registered signal, equal to skid empty.
  - When the output is stalled, one more upstream instruction is captured into the skid entry, then ready_out deasserts.
  - On drain, the skid entry moves to the output first (order preserved).
- Undefined:
  - Single output register; ready_out = !valid_out || ready_in (combinational).

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → next cycle valid_out=1, op1=5, op2=7, opcode 0000, rd=3, wr_en=1.
- SUB (0x402081B3) → opcode 1000. SRAI x5,x6,3 (0x40335293), rs1=0x80000000 → op2=0x00000003, opcode 1101.
- ADDI x1,x0,-1 (0xFFF00093) → op2=0xFFFFFFFF, opcode 0000. LUI x2,0x12345 (0x12345137) → op1=0, op2=0x12345000. AUIPC with pc_in=0x100 → op1=0x100.
- Backpressure: ready_in=0 for 3 cycles with valid_in held → outputs stable. With SKID_EN, exactly one extra instruction is accepted, then ready_out=0. After ready_in=1, both issue in order.
- flush_in pulse while valid_out=1 and skid full → next cycle valid_out=0, ready_out=1; the concurrently presented instruction is never issued.
- opcode 0x7F, or instr 0x00000033 with rd=0, or OP with funct7 0x01 (CHECK_FUNCT7=1) → illegal_out=1 or wr_en_out=0 as specified; async reset mid-stall → all outputs 0 immediately.
